fpuadd64_issue: RTL
===================

// Module: fpuadd64_issue
// PURPOSE
//  Issue/retire stage wrapped around the 64-bit FP adder (sign[63], exp[62:53] bias 10'h200, mant[52:0]).
//  Buffers incoming add/sub/seed requests and drives the adder's A/B/rnd/pookm/pookg inputs.
//  The adder has no stall, so issue is credit-limited against a result buffer.
//  Captures res LAT cycles after issue and returns it tagged under valid/ready.
// PARAMETERS
//  DEPTH  4  request FIFO entries (power of 2, >=2)
//  LAT    2  adder issue-to-res latency in cycles (>=1)
//  TAGW   4  request tag width, passed through unchanged
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous reset, active-low
//  in_vld     in   1     request valid
//  in_rdy     out  1     request FIFO not full
//  in_op      in   2     00 add, 01 sub, 10 seed-div, 11 seed-rsqrt
//  in_a       in   64    operand A
//  in_b       in   64    operand B (ignored for seed ops)
//  in_rnd     in   1     round bit for add/sub
//  in_tag     in   TAGW  request tag
//  fa_a       out  64    adder A
//  fa_b       out  64    adder B
//  fa_rnd     out  1     adder rnd
//  fa_pookm   out  1     adder pookm
//  fa_pookg   out  1     adder pookg (table/seed path select)
//  fa_res     in   64    adder result
//  out_vld    out  1     result valid
//  out_rdy    in   1     consumer ready
//  out_res    out  64    result
//  out_tag    out  TAGW  tag of the result
// BEHAVIOUR
//  Reset (rst=0, async): FIFO/result buffer empty, pipe valids 0, credits=LAT+2; in_rdy=0 during reset, 1 after;
//   out_vld=0, out_res=0, out_tag=0, fa_* all 0.
//  Accept: in_vld&in_rdy pushes {op,a,b,rnd,tag}. in_rdy=!fifo_full, registered, independent of out_rdy.
//  Issue: when FIFO non-empty and credits>0, pop head and register fa_* in the same edge; credits-1.
//   add: fa_a=a, fa_b=b, fa_pookm=1, fa_pookg=0, fa_rnd=rnd.
//   sub: as add but fa_b[63]=~b[63].
//   seed-div: fa_a=a, fa_b=0, fa_rnd=0, fa_pookm=1, fa_pookg=1.
//   seed-rsqrt: as seed-div but fa_rnd=1 (selects the rsqrt table half and exponent halving).
//   No issue: fa_* hold previous values (bubble); pipe valid bit 0.
//  Tracking: LAT-deep shift register of {vld,tag}; at stage LAT capture fa_res with tag into result buffer.
//  Result buffer: LAT+2 entries FIFO; head drives out_*; pop on out_vld&out_rdy -> credits+1.
//   Simultaneous issue and pop same cycle: credits unchanged.
//   credits never exceeds LAT+2 nor underflows; buffer therefore cannot overflow.
//  Throughput: one op/cycle while out_rdy=1; request-to-out_vld latency 1+LAT+1 cycles from empty.
//  Order: results strictly in request order; no reordering.
//  FIFO full + push attempt: ignored (in_rdy=0); empty + pop: no-op.
//  Pointers: log2 wrap with extra MSB for full/empty distinction.
//  Reset mid-operation: all in-flight and buffered ops discarded, no out_vld after release until new issue.
//  out_res/out_tag hold last value when out_vld=0.
// STRUCTURE
//  fpu64_pkg: EXPW=10, MANW=53, BIAS=10'h200, op enum {OP_ADD,OP_SUB,OP_SDIV,OP_SRSQ}, request struct.
//  Sub-module fpu_sync_fifo (param WIDTH, DEPTH), instanced for request FIFO and result buffer.
//  Top holds issue decode, credit counter, latency shift register.
// TESTING
//  1: reset, add A=0x4000000000000000 B=0x4000000000000000 tag 3 -> fa_pookm=1,fa_pookg=0; out_vld at cycle 1+LAT+1, out_tag=3.
//  2: sub with B=0x4000000000000000 -> fa_b=0xC000000000000000, fa_pookm=1.
//  3: seed-rsqrt A=0x4040000000000000 -> fa_rnd=1, fa_pookg=1, fa_b=0.
//  4: out_rdy=0, push 10 ops back-to-back -> exactly LAT+2 issue, in_rdy drops after DEPTH more; none lost, order kept on release.
//  5: out_rdy toggling 1/0 with in_vld=1 continuous -> tags 0..15 return in order, credits never <0 or >LAT+2.
//  6: assert rst low with 3 ops in flight -> out_vld=0 immediately, no stale result after rst high.

Source files
------------

// File: rtl/fpuadd64_issue_pkg.sv
// Shared FP64 field geometry, request opcodes and the buffered request record
// for the adder issue/retire stage.
package fpu64_pkg;

  localparam int unsigned EXPW = 10;
  localparam int unsigned MANW = 53;
  localparam logic [EXPW-1:0] BIAS = 10'h200;
  localparam int unsigned SIGN = EXPW + MANW;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_SDIV = 2'b10,
    OP_SRSQ = 2'b11
  } op_e;

  typedef struct packed {
    op_e           op;
    logic [SIGN:0] a;
    logic [SIGN:0] b;
    logic          rnd;
  } req_t;

  function automatic logic [SIGN:0] flip_sign(input logic [SIGN:0] x);
    return {~x[SIGN], x[SIGN-1:0]};
  endfunction

endpackage

// File: rtl/fpuadd64_issue_if.sv
// Request, adder-drive and result handshake bundle for fpuadd64_issue.
interface fpuadd64_issue_if #(
  parameter int unsigned TAGW = 4
);
  logic            in_vld;
  logic            in_rdy;
  logic [1:0]      in_op;
  logic [63:0]     in_a;
  logic [63:0]     in_b;
  logic            in_rnd;
  logic [TAGW-1:0] in_tag;
  logic [63:0]     fa_a;
  logic [63:0]     fa_b;
  logic            fa_rnd;
  logic            fa_pookm;
  logic            fa_pookg;
  logic [63:0]     fa_res;
  logic            out_vld;
  logic            out_rdy;
  logic [63:0]     out_res;
  logic [TAGW-1:0] out_tag;

  modport slave (
    input  in_vld, in_op, in_a, in_b, in_rnd, in_tag, fa_res, out_rdy,
    output in_rdy, fa_a, fa_b, fa_rnd, fa_pookm, fa_pookg, out_vld, out_res, out_tag
  );

  modport master (
    output in_vld, in_op, in_a, in_b, in_rnd, in_tag, fa_res, out_rdy,
    input  in_rdy, fa_a, fa_b, fa_rnd, fa_pookm, fa_pookg, out_vld, out_res, out_tag
  );
endinterface

// File: rtl/fpuadd64_issue_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push-when-full and pop-when-empty
// are ignored. Head entry is presented combinationally on data_o.
module fpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wp_q, rp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/fpuadd64_issue.sv
// Issue/retire stage for the 64-bit FP adder: buffers requests, issues against
// result-buffer credits, tracks adder latency and returns tagged results in order.
module fpuadd64_issue
  import fpu64_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  fpuadd64_issue_if.slave bus
);
  localparam int unsigned REQW   = $bits(req_t) + TAGW;
  localparam int unsigned RESW   = 64 + TAGW;
  localparam int unsigned RDEPTH = 1 << $clog2(LAT + 2);
  localparam int unsigned CRW    = $clog2(LAT + 3);
  localparam logic [CRW-1:0] CRED_MAX = CRW'(LAT + 2);

  logic            rdy_en_q;
  logic            req_full, req_empty, req_push, issue;
  req_t            req_in, head;
  logic [TAGW-1:0] head_tag;
  logic [REQW-1:0] req_rdata;

  logic [CRW-1:0]  cred_q, cred_d;
  logic            vld_q [LAT];
  logic [TAGW-1:0] tag_q [LAT];

  logic [63:0] fa_a_q, fa_a_d, fa_b_q, fa_b_d;
  logic        fa_rnd_q, fa_rnd_d, fa_pookm_q, fa_pookm_d, fa_pookg_q, fa_pookg_d;

  logic            res_empty, res_full_unused, res_pop;
  logic [RESW-1:0] res_rdata;
  logic [63:0]     last_res_q;
  logic [TAGW-1:0] last_tag_q;

  assign req_in   = '{op: op_e'(bus.in_op), a: bus.in_a, b: bus.in_b, rnd: bus.in_rnd};
  assign req_push = bus.in_vld & bus.in_rdy;
  assign {head_tag, head} = req_rdata;
  assign issue    = ~req_empty & (cred_q != '0);
  assign res_pop  = ~res_empty & bus.out_rdy;

  fpu_sync_fifo #(.WIDTH(REQW), .DEPTH(DEPTH)) u_req_fifo (
    .clk_i(clk), .rst_ni(rst),
    .push_i(req_push), .data_i({bus.in_tag, req_in}),
    .pop_i(issue), .data_o(req_rdata),
    .empty_o(req_empty), .full_o(req_full)
  );

  // Sized to a power of two; credits cap actual occupancy at LAT+2.
  fpu_sync_fifo #(.WIDTH(RESW), .DEPTH(RDEPTH)) u_res_fifo (
    .clk_i(clk), .rst_ni(rst),
    .push_i(vld_q[LAT-1]), .data_i({tag_q[LAT-1], bus.fa_res}),
    .pop_i(res_pop), .data_o(res_rdata),
    .empty_o(res_empty), .full_o(res_full_unused)
  );

  always_comb begin
    fa_a_d     = fa_a_q;
    fa_b_d     = fa_b_q;
    fa_rnd_d   = fa_rnd_q;
    fa_pookm_d = fa_pookm_q;
    fa_pookg_d = fa_pookg_q;
    if (issue) begin
      fa_a_d     = head.a;
      fa_pookm_d = 1'b1;
      unique case (head.op)
        OP_ADD:  begin fa_b_d = head.b;            fa_rnd_d = head.rnd; fa_pookg_d = 1'b0; end
        OP_SUB:  begin fa_b_d = flip_sign(head.b); fa_rnd_d = head.rnd; fa_pookg_d = 1'b0; end
        OP_SDIV: begin fa_b_d = '0;                fa_rnd_d = 1'b0;     fa_pookg_d = 1'b1; end
        OP_SRSQ: begin fa_b_d = '0;                fa_rnd_d = 1'b1;     fa_pookg_d = 1'b1; end
      endcase
    end
  end

  always_comb begin
    cred_d = cred_q;
    if (issue && !res_pop)      cred_d = cred_q - CRW'(1);
    else if (!issue && res_pop) cred_d = cred_q + CRW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q   <= 1'b0;
      cred_q     <= CRED_MAX;
      fa_a_q     <= '0;
      fa_b_q     <= '0;
      fa_rnd_q   <= 1'b0;
      fa_pookm_q <= 1'b0;
      fa_pookg_q <= 1'b0;
      last_res_q <= '0;
      last_tag_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      rdy_en_q   <= 1'b1;
      cred_q     <= cred_d;
      fa_a_q     <= fa_a_d;
      fa_b_q     <= fa_b_d;
      fa_rnd_q   <= fa_rnd_d;
      fa_pookm_q <= fa_pookm_d;
      fa_pookg_q <= fa_pookg_d;
      if (res_pop) begin
        last_res_q <= res_rdata[63:0];
        last_tag_q <= res_rdata[RESW-1:64];
      end
      vld_q[0] <= issue;
      tag_q[0] <= head_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.in_rdy   = rdy_en_q & ~req_full;
  assign bus.fa_a     = fa_a_q;
  assign bus.fa_b     = fa_b_q;
  assign bus.fa_rnd   = fa_rnd_q;
  assign bus.fa_pookm = fa_pookm_q;
  assign bus.fa_pookg = fa_pookg_q;
  assign bus.out_vld  = ~res_empty;
  assign bus.out_res  = res_empty ? last_res_q : res_rdata[63:0];
  assign bus.out_tag  = res_empty ? last_tag_q : res_rdata[RESW-1:64];
endmodule
